// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator for the overlay pipeline.
// Produces x/y scan coordinates, the active-video flag, hsync/vsync and
// line/frame start pulses. All timing is set through parameters; the
// default is 640x480 @ 60 Hz (800 x 525 totals, 25.175 MHz pixel clock).
// The counters advance only on cycles with pix_en=1.
//
// Optional build macro:
//   FRAME_COUNTER_EN - adds the 8-bit frame_count output, which counts
//                      completed frames and wraps 255 -> 0.
//
// Every output is registered and decoded from the next counter state, so
// x, y, active, hsync and vsync always describe the same pixel.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter logic        HSYNC_POL = 1'b0,
  parameter logic        VSYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
`ifdef FRAME_COUNTER_EN
  ,
  output logic [7:0] frame_count
`endif
);

  // Line and frame totals; both must fit the 10-bit counters (<= 1024).
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last coordinate of a line / frame, where the counters wrap.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode boundaries kept at 11 bits so an end boundary equal to 1024
  // still compares correctly against a 10-bit coordinate.
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEGIN   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEGIN   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Counter state and registered outputs.
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  // Wrap conditions of the current position.
  logic       h_wrap;
  logic       v_wrap;

  // Widened next-state coordinates used by the range decoders.
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        in_hsync;
  logic        in_vsync;

  // Next counter state: x steps every enabled cycle, y steps on x wrap.
  always_comb begin
    h_wrap = (x_q == H_LAST);
    v_wrap = h_wrap && (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (pix_en) begin
      x_d = h_wrap ? 10'd0 : x_q + 10'd1;
      if (h_wrap) begin
        y_d = v_wrap ? 10'd0 : y_q + 10'd1;
      end
    end
  end

  // Decode outputs from the next counter state so they line up with x/y.
  always_comb begin
    x_ext         = {1'b0, x_d};
    y_ext         = {1'b0, y_d};
    in_hsync      = (x_ext >= HS_BEGIN) && (x_ext < HS_END);
    in_vsync      = (y_ext >= VS_BEGIN) && (y_ext < VS_END);
    active_d      = (x_ext < H_ACT_END) && (y_ext < V_ACT_END);
    hsync_d       = in_hsync ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = in_vsync ? VSYNC_POL : ~VSYNC_POL;
    // Pulses only follow a real enabled wrap, so a stall clears them.
    line_start_d  = pix_en && h_wrap;
    frame_start_d = pix_en && v_wrap;
  end

  // State registers; reset lands on (0,0) with syncs deasserted and no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      active_q      <= 1'b1;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef FRAME_COUNTER_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Count completed frames on the same edge that raises frame_start.
  always_comb begin
    frame_count_d = frame_count_q;
    if (pix_en && v_wrap) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Frame counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count_q <= 8'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen.
// DUT a uses the default 640x480 timing (horizontal and stall checks).
// DUT b uses a tiny 10x8 raster with active-high hsync so whole frames,
// mid-frame reset and the optional frame counter fit in a short run.
// Small raster: H 6+1+2+1 = 10, V 4+1+2+1 = 8, 80 cycles per frame;
// hsync high for x=7..8, vsync low for y=5..6.
module tb_vga_timing_gen;

  logic       clk;
  logic       rst_a, pix_en_a;
  logic [9:0] x_a, y_a;
  logic       active_a, hsync_a, vsync_a, line_start_a, frame_start_a;
  logic       rst_b, pix_en_b;
  logic [9:0] x_b, y_b;
  logic       active_b, hsync_b, vsync_b, line_start_b, frame_start_b;
`ifdef FRAME_COUNTER_EN
  logic [7:0] frame_count_a, frame_count_b;
`endif

  int tests;
  int fails;

  vga_timing_gen dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .pix_en      (pix_en_a),
    .x           (x_a),
    .y           (y_a),
    .active      (active_a),
    .hsync       (hsync_a),
    .vsync       (vsync_a),
    .line_start  (line_start_a),
    .frame_start (frame_start_a)
`ifdef FRAME_COUNTER_EN
    ,
    .frame_count (frame_count_a)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .pix_en      (pix_en_b),
    .x           (x_b),
    .y           (y_b),
    .active      (active_b),
    .hsync       (hsync_b),
    .vsync       (vsync_b),
    .line_start  (line_start_b),
    .frame_start (frame_start_b)
`ifdef FRAME_COUNTER_EN
    ,
    .frame_count (frame_count_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two reset edges, release at a negedge; the DUT then shows cycle 0.
  task automatic do_reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    pix_en_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic do_reset_b();
    @(negedge clk);
    rst_b = 1'b1;
    pix_en_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    do_reset_a();
    do_reset_b();
    repeat (5) @(negedge clk);
    do_reset_a();
    tests++; if (x_a !== 10'd0) begin fails++; $display("FAIL reset_x_a got %0d exp 0", x_a); end
    tests++; if (y_a !== 10'd0) begin fails++; $display("FAIL reset_y_a got %0d exp 0", y_a); end
    tests++; if (active_a !== 1'b1) begin fails++; $display("FAIL reset_active_a got %b exp 1", active_a); end
    tests++; if (hsync_a !== 1'b1) begin fails++; $display("FAIL reset_hsync_a got %b exp 1", hsync_a); end
    tests++; if (vsync_a !== 1'b1) begin fails++; $display("FAIL reset_vsync_a got %b exp 1", vsync_a); end
    tests++; if (line_start_a !== 1'b0) begin fails++; $display("FAIL reset_ls_a got %b exp 0", line_start_a); end
    tests++; if (frame_start_a !== 1'b0) begin fails++; $display("FAIL reset_fs_a got %b exp 0", frame_start_a); end
    do_reset_b();
    tests++; if (hsync_b !== 1'b0) begin fails++; $display("FAIL reset_hsync_b got %b exp 0", hsync_b); end
    tests++; if (vsync_b !== 1'b1) begin fails++; $display("FAIL reset_vsync_b got %b exp 1", vsync_b); end
    tests++; if (x_b !== 10'd0 || y_b !== 10'd0) begin fails++; $display("FAIL reset_xy_b got (%0d,%0d) exp (0,0)", x_b, y_b); end
`ifdef FRAME_COUNTER_EN
    tests++; if (frame_count_b !== 8'd0) begin fails++; $display("FAIL reset_fc_b got %0d exp 0", frame_count_b); end
`endif
    $display("[TB] test_reset done");
  endtask

  task automatic test_horizontal();
    int hs_low;
    int hs_first;
    int xe;
    int ye;
    logic ae, he, le;
    hs_low = 0;
    hs_first = -1;
    do_reset_a();
    for (int i = 1; i <= 800; i++) begin
      @(negedge clk);
      xe = i % 800;
      ye = i / 800;
      ae = (xe < 640);
      he = !(xe >= 656 && xe < 752);
      le = (xe == 0);
      tests++; if (x_a !== 10'(xe)) begin fails++; $display("FAIL horiz_x cyc %0d got %0d exp %0d", i, x_a, xe); end
      tests++; if (y_a !== 10'(ye)) begin fails++; $display("FAIL horiz_y cyc %0d got %0d exp %0d", i, y_a, ye); end
      tests++; if (active_a !== ae) begin fails++; $display("FAIL horiz_active cyc %0d got %b exp %b", i, active_a, ae); end
      tests++; if (hsync_a !== he) begin fails++; $display("FAIL horiz_hsync cyc %0d got %b exp %b", i, hsync_a, he); end
      tests++; if (line_start_a !== le) begin fails++; $display("FAIL horiz_ls cyc %0d got %b exp %b", i, line_start_a, le); end
      if (hsync_a === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(x_a);
      end
    end
    tests++; if (hs_low != 96) begin fails++; $display("FAIL horiz_hs_width got %0d exp 96", hs_low); end
    tests++; if (hs_first != 656) begin fails++; $display("FAIL horiz_hs_start got %0d exp 656", hs_first); end
    $display("[TB] test_horizontal done: hsync low %0d cycles from x=%0d", hs_low, hs_first);
  endtask

  task automatic test_stall();
    logic pe_seq [4];
    int   x_seq [4];
    pe_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
    x_seq  = '{639, 639, 639, 640};
    do_reset_a();
    repeat (638) @(negedge clk);
    tests++; if (x_a !== 10'd638) begin fails++; $display("FAIL stall_pre got %0d exp 638", x_a); end
    for (int k = 0; k < 4; k++) begin
      pix_en_a = pe_seq[k];
      @(negedge clk);
      tests++; if (x_a !== 10'(x_seq[k])) begin fails++; $display("FAIL stall_x step %0d got %0d exp %0d", k, x_a, x_seq[k]); end
      tests++; if (active_a !== 1'b1 && k < 3) begin fails++; $display("FAIL stall_active step %0d got %b exp 1", k, active_a); end
    end
    pix_en_a = 1'b1;
    repeat (159) @(negedge clk);
    tests++; if (x_a !== 10'd799) begin fails++; $display("FAIL stall_x799 got %0d exp 799", x_a); end
    @(negedge clk);
    tests++; if (line_start_a !== 1'b1 || x_a !== 10'd0 || y_a !== 10'd1) begin
      fails++; $display("FAIL stall_wrap got ls=%b x=%0d y=%0d exp ls=1 x=0 y=1", line_start_a, x_a, y_a);
    end
    pix_en_a = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++; if (line_start_a !== 1'b0 || x_a !== 10'd0 || y_a !== 10'd1) begin
        fails++; $display("FAIL stall_hold step %0d got ls=%b x=%0d y=%0d exp ls=0 x=0 y=1", k, line_start_a, x_a, y_a);
      end
    end
    pix_en_a = 1'b1;
    @(negedge clk);
    tests++; if (line_start_a !== 1'b0 || x_a !== 10'd1) begin
      fails++; $display("FAIL stall_resume got ls=%b x=%0d exp ls=0 x=1", line_start_a, x_a);
    end
    $display("[TB] test_stall done");
  endtask

  task automatic test_vertical();
    int xe, ye, vs_low, fs_cnt, fs_first, fs_last;
    logic ae, he, ve, le, fe;
    vs_low = 0; fs_cnt = 0; fs_first = -1; fs_last = -1;
    do_reset_b();
    for (int i = 1; i <= 160; i++) begin
      @(negedge clk);
      xe = i % 10;
      ye = (i / 10) % 8;
      ae = (xe < 6) && (ye < 4);
      he = (xe >= 7 && xe < 9);
      ve = !(ye >= 5 && ye < 7);
      le = (xe == 0);
      fe = (i % 80 == 0);
      tests++; if (x_b !== 10'(xe) || y_b !== 10'(ye)) begin fails++; $display("FAIL vert_xy cyc %0d got (%0d,%0d) exp (%0d,%0d)", i, x_b, y_b, xe, ye); end
      tests++; if (active_b !== ae) begin fails++; $display("FAIL vert_active cyc %0d got %b exp %b", i, active_b, ae); end
      tests++; if (hsync_b !== he) begin fails++; $display("FAIL vert_hsync cyc %0d got %b exp %b", i, hsync_b, he); end
      tests++; if (vsync_b !== ve) begin fails++; $display("FAIL vert_vsync cyc %0d got %b exp %b", i, vsync_b, ve); end
      tests++; if (line_start_b !== le) begin fails++; $display("FAIL vert_ls cyc %0d got %b exp %b", i, line_start_b, le); end
      tests++; if (frame_start_b !== fe) begin fails++; $display("FAIL vert_fs cyc %0d got %b exp %b", i, frame_start_b, fe); end
      if (i <= 80 && vsync_b === 1'b0) vs_low++;
      if (frame_start_b === 1'b1) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = i;
        fs_last = i;
      end
    end
    tests++; if (vs_low != 20) begin fails++; $display("FAIL vert_vs_width got %0d exp 20", vs_low); end
    tests++; if (fs_cnt != 2 || fs_last - fs_first != 80) begin
      fails++; $display("FAIL vert_fs_spacing got count %0d gap %0d exp count 2 gap 80", fs_cnt, fs_last - fs_first);
    end
    $display("[TB] test_vertical done: vsync low %0d cycles, %0d frame pulses", vs_low, fs_cnt);
  endtask

  task automatic test_mid_reset();
    int xe, ye;
    logic fe;
    do_reset_b();
    repeat (23) @(negedge clk);
    tests++; if (x_b !== 10'd3 || y_b !== 10'd2) begin fails++; $display("FAIL midrst_pre got (%0d,%0d) exp (3,2)", x_b, y_b); end
    rst_b = 1'b1;
    pix_en_b = 1'b0;
    @(negedge clk);
    tests++; if (x_b !== 10'd0 || y_b !== 10'd0) begin fails++; $display("FAIL midrst_xy got (%0d,%0d) exp (0,0)", x_b, y_b); end
    tests++; if (frame_start_b !== 1'b0 || line_start_b !== 1'b0) begin
      fails++; $display("FAIL midrst_pulse got fs=%b ls=%b exp 0 0", frame_start_b, line_start_b);
    end
    tests++; if (active_b !== 1'b1) begin fails++; $display("FAIL midrst_active got %b exp 1", active_b); end
    rst_b = 1'b0;
    pix_en_b = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      xe = i % 10;
      ye = (i / 10) % 8;
      fe = (i == 80);
      tests++; if (x_b !== 10'(xe) || y_b !== 10'(ye)) begin fails++; $display("FAIL midrst_xy cyc %0d got (%0d,%0d) exp (%0d,%0d)", i, x_b, y_b, xe, ye); end
      tests++; if (frame_start_b !== fe) begin fails++; $display("FAIL midrst_fs cyc %0d got %b exp %b", i, frame_start_b, fe); end
    end
    $display("[TB] test_mid_reset done");
  endtask

`ifdef FRAME_COUNTER_EN
  task automatic test_frame_counter();
    do_reset_b();
    tests++; if (frame_count_b !== 8'd0) begin fails++; $display("FAIL fc_start got %0d exp 0", frame_count_b); end
    for (int i = 1; i <= 257 * 80; i++) begin
      @(negedge clk);
      if (i == 80) begin
        tests++; if (frame_count_b !== 8'd1 || frame_start_b !== 1'b1) begin
          fails++; $display("FAIL fc_first got fc=%0d fs=%b exp fc=1 fs=1", frame_count_b, frame_start_b);
        end
      end
      if (i == 256 * 80) begin
        tests++; if (frame_count_b !== 8'd0) begin fails++; $display("FAIL fc_wrap got %0d exp 0", frame_count_b); end
      end
    end
    tests++; if (frame_count_b !== 8'd1) begin fails++; $display("FAIL fc_257 got %0d exp 1", frame_count_b); end
    pix_en_b = 1'b0;
    @(negedge clk);
    tests++; if (frame_count_b !== 8'd1) begin fails++; $display("FAIL fc_hold got %0d exp 1", frame_count_b); end
    pix_en_b = 1'b1;
    $display("[TB] test_frame_counter done: frame_count=%0d", frame_count_b);
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst_a = 1'b1; pix_en_a = 1'b0;
    rst_b = 1'b1; pix_en_b = 1'b0;
    test_reset();
    test_horizontal();
    test_stall();
    test_vertical();
    test_mid_reset();
`ifdef FRAME_COUNTER_EN
    test_frame_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
